// File: rtl/g711_pkg.sv
// Shared A-law receive definitions: framer states, code constants and the
// 8-bit code to 13-bit sign-magnitude expansion.
package g711_pkg;

    localparam logic [1:0]  SEG1_CODE_MSBS = 2'b00;
    localparam logic [11:0] ALAW_MAX_MAG   = 12'd4032;

    typedef enum logic [1:0] {
        HUNT,
        SHIFT,
        WAIT_FS
    } frm_state_t;

    // Segments 0 and 1 share one step size, so c[4] acts as a fifth mantissa bit.
    // Higher segments place {1, m, 1} so that its top bit lands on bit seg+4.
    function automatic logic [12:0] alaw_expand(input logic [7:0] code);
        logic [2:0]  seg;
        logic [11:0] mag;
        seg = code[6:4];
        if (code[6:5] == SEG1_CODE_MSBS)
            mag = {6'b0, code[4:0], 1'b1};
        else
            mag = 12'({1'b1, code[3:0], 1'b1}) << (seg - 3'd1);
        if (mag > ALAW_MAX_MAG)
            mag = ALAW_MAX_MAG;
        return {code[7], mag};
    endfunction

endpackage

// File: rtl/g711alaw_rx_expander_if.sv
// Sample stream toward the DSP chain: valid/ready with the masked code and
// its linear sign-magnitude expansion.
interface g711alaw_rx_expander_if;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_code;
    logic [12:0] dec;

    modport master (output out_valid, output out_code, output dec, input out_ready);
    modport slave  (input out_valid, input out_code, input dec, output out_ready);
endinterface

// File: rtl/g711_alaw_deframer.sv
// Frame-sync/bit-enable deframer: collects MSB-first 8-bit codes and flags
// a frame sync that arrives while a code is still being shifted in.
module g711_alaw_deframer
    import g711_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_en,
    input  logic       fs,
    input  logic       sdin,
    output logic       code_done,
    output logic [7:0] code,
    output logic       sync_err
);

    frm_state_t state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [6:0] shreg, shreg_n;
    logic       err_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= HUNT;
            cnt      <= '0;
            shreg    <= '0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            shreg    <= shreg_n;
            sync_err <= err_n;
        end
    end

    // The 8th bit is taken straight from sdin so the code is ready at its strobe.
    assign code = {shreg, sdin};

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shreg_n   = shreg;
        err_n     = 1'b0;
        code_done = 1'b0;
        unique case (state)
            HUNT, WAIT_FS: begin
                if (bit_en && fs) begin
                    shreg_n = {6'b0, sdin};
                    cnt_n   = 3'd1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    if (cnt == 3'd7) begin
                        // fs on the last bit is part of this code, not a restart
                        code_done = 1'b1;
                        cnt_n     = '0;
                        state_n   = WAIT_FS;
                    end else if (fs && cnt != '0) begin
                        err_n   = 1'b1;
                        shreg_n = {6'b0, sdin};
                        cnt_n   = 3'd1;
                    end else begin
                        shreg_n = {shreg[5:0], sdin};
                        cnt_n   = cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_n = HUNT;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: rtl/g711alaw_rx_expander.sv
// G.711 A-law receiver: deframes serial codes, holds them in a two-stage
// pipeline and presents expanded linear samples on a valid/ready port.
module g711alaw_rx_expander
    import g711_pkg::*;
#(
    parameter logic [7:0]  XOR_MASK = 8'h00,
    parameter int unsigned WIDTH    = 13
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            bit_en,
    input  logic                            fs,
    input  logic                            sdin,
    g711alaw_rx_expander_if.master          pcm,
    output logic                            overrun,
    output logic                            sync_err
);

    logic             code_done;
    logic [7:0]       rx_code;
    logic [7:0]       s1_code;
    logic             code_vld;
    logic             s2_load;
    logic             out_valid;
    logic [7:0]       out_code;
    logic [WIDTH-1:0] dec;

    g711_alaw_deframer u_deframer (
        .clk       (clk),
        .reset     (reset),
        .bit_en    (bit_en),
        .fs        (fs),
        .sdin      (sdin),
        .code_done (code_done),
        .code      (rx_code),
        .sync_err  (sync_err)
    );

    assign s2_load = code_vld && (!out_valid || pcm.out_ready);

    // Stage 1 can take a new code in the same cycle it hands its old one to stage 2.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_code  <= '0;
            code_vld <= 1'b0;
            overrun  <= 1'b0;
        end else if (code_done) begin
            if (!code_vld || s2_load) begin
                s1_code  <= rx_code ^ XOR_MASK;
                code_vld <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (s2_load) begin
            code_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_code  <= '0;
            dec       <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_code  <= s1_code;
            dec       <= alaw_expand(s1_code);
        end else if (pcm.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign pcm.out_valid = out_valid;
    assign pcm.out_code  = out_code;
    assign pcm.dec       = dec;

endmodule

// File: tb/tb_g711alaw_rx_expander.sv
// Self-checking bench for the A-law receiver: directed scenarios plus a
// randomized stream checked against an arithmetic expansion model.
module tb_g711alaw_rx_expander;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic bit_en = 1'b0;
    logic fs = 1'b0;
    logic sdin = 1'b0;
    logic overrun0, sync_err0, overrun1, sync_err1;
    logic rdy = 1'b1;

    int n_tests = 0;
    int n_fail = 0;
    int sync_seen = 0;
    int xfer_seen = 0;
    logic [12:0] last_dec;
    logic [7:0]  last_code;

    g711alaw_rx_expander_if i0 ();
    g711alaw_rx_expander_if i1 ();

    g711alaw_rx_expander #(.XOR_MASK(8'h00), .WIDTH(13)) dut0 (
        .clk(clk), .reset(reset), .bit_en(bit_en), .fs(fs), .sdin(sdin),
        .pcm(i0), .overrun(overrun0), .sync_err(sync_err0)
    );

    g711alaw_rx_expander #(.XOR_MASK(8'h55), .WIDTH(13)) dut1 (
        .clk(clk), .reset(reset), .bit_en(bit_en), .fs(fs), .sdin(sdin),
        .pcm(i1), .overrun(overrun1), .sync_err(sync_err1)
    );

    always #5 clk = ~clk;

    // Segment k >= 2 spans [2^(k+4), 2^(k+5)) in steps of 2^k; the decision
    // value sits half a step above the interval start.
    function automatic logic [12:0] ref_expand(input int c);
        int s, seg, m, mag;
        s   = (c >> 7) & 1;
        seg = (c >> 4) & 7;
        m   = c & 15;
        if (seg <= 1) mag = 2 * (c & 31) + 1;
        else          mag = (1 << (seg + 4)) + m * (1 << seg) + (1 << (seg - 1));
        return 13'(s * 4096 + mag);
    endfunction

    task automatic step(input logic be, input logic f, input logic d);
        @(posedge clk);
        #1;
        bit_en = be;
        fs = f;
        sdin = d;
        i0.out_ready = rdy;
        @(negedge clk);
        if (sync_err0) sync_seen++;
        if (i0.out_valid && i0.out_ready) begin
            xfer_seen++;
            last_dec = i0.dec;
            last_code = i0.out_code;
        end
    endtask

    task automatic send_code(input logic [7:0] c, input logic with_fs);
        for (int i = 7; i >= 0; i--)
            step(1'b1, with_fs && (i == 7), c[i]);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        rdy = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (i0.out_valid !== 1'b0 || i0.dec !== 13'h0 || i0.out_code !== 8'h0 ||
            overrun0 !== 1'b0 || sync_err0 !== 1'b0 || i1.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b dec=%h code=%h ovr=%b serr=%b v1=%b required all 0",
                     i0.out_valid, i0.dec, i0.out_code, overrun0, sync_err0, i1.out_valid);
        end
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_decode;
        logic [7:0]  codes [5];
        logic [12:0] exp_dec [5];
        codes = '{8'h00, 8'h15, 8'h25, 8'h85, 8'h7F};
        exp_dec = '{13'h0001, 13'h002B, 13'h0056, 13'h100B, 13'h0FC0};
        rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            send_code(codes[k], 1'b1);
            step(1'b0, 1'b0, 1'b0);
            n_tests++;
            if (i0.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL decode_latency_n1[%0h]: valid=%b required 0", codes[k], i0.out_valid);
            end
            step(1'b0, 1'b0, 1'b0);
            n_tests++;
            if (i0.out_valid !== 1'b1 || i0.dec !== exp_dec[k] || i0.out_code !== codes[k]) begin
                n_fail++;
                $display("FAIL decode[%0h]: valid=%b dec=%h code=%h required valid=1 dec=%h code=%h",
                         codes[k], i0.out_valid, i0.dec, i0.out_code, exp_dec[k], codes[k]);
            end
            step(1'b0, 1'b0, 1'b0);
            n_tests++;
            if (i0.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL decode_drain[%0h]: valid=%b required 0", codes[k], i0.out_valid);
            end
        end
    endtask

    task automatic test_xor_mask;
        rdy = 1'b1;
        send_code(8'hD5, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (i1.out_valid !== 1'b1 || i1.out_code !== 8'h80 || i1.dec !== 13'h1001) begin
            n_fail++;
            $display("FAIL xor_mask: valid=%b code=%h dec=%h required valid=1 code=80 dec=1001",
                     i1.out_valid, i1.out_code, i1.dec);
        end
        n_tests++;
        if (i0.out_code !== 8'hD5 || i0.dec !== ref_expand(8'hD5)) begin
            n_fail++;
            $display("FAIL no_mask: code=%h dec=%h required code=d5 dec=%h",
                     i0.out_code, i0.dec, ref_expand(8'hD5));
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_sync_err;
        int s0, x0;
        rdy = 1'b1;
        s0 = sync_seen;
        x0 = xfer_seen;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        send_code(8'h7F, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (sync_seen - s0 !== 1) begin
            n_fail++;
            $display("FAIL sync_err_pulses: got %0d required 1", sync_seen - s0);
        end
        n_tests++;
        if (xfer_seen - x0 !== 1 || last_dec !== 13'h0FC0) begin
            n_fail++;
            $display("FAIL sync_restart: samples=%0d dec=%h required 1 sample dec=0fc0",
                     xfer_seen - x0, last_dec);
        end
    endtask

    task automatic test_overrun;
        logic [7:0] a, b, c;
        a = 8'($urandom);
        b = 8'($urandom);
        c = 8'($urandom);
        rdy = 1'b0;
        send_code(a, 1'b1);
        send_code(b, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (overrun0 !== 1'b0 || i0.out_valid !== 1'b1 || i0.dec !== ref_expand(a)) begin
            n_fail++;
            $display("FAIL overrun_two_held: ovr=%b valid=%b dec=%h required ovr=0 valid=1 dec=%h",
                     overrun0, i0.out_valid, i0.dec, ref_expand(a));
        end
        send_code(c, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (overrun0 !== 1'b1 || i0.dec !== ref_expand(a)) begin
            n_fail++;
            $display("FAIL overrun_third: ovr=%b dec=%h required ovr=1 dec=%h",
                     overrun0, i0.dec, ref_expand(a));
        end
        rdy = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (i0.out_valid !== 1'b1 || i0.dec !== ref_expand(a) || i0.out_code !== a) begin
            n_fail++;
            $display("FAIL overrun_first_out: valid=%b dec=%h code=%h required dec=%h code=%h",
                     i0.out_valid, i0.dec, i0.out_code, ref_expand(a), a);
        end
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (i0.out_valid !== 1'b1 || i0.dec !== ref_expand(b) || i0.out_code !== b || overrun0 !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_second_out: valid=%b dec=%h code=%h ovr=%b required dec=%h code=%h ovr=1",
                     i0.out_valid, i0.dec, i0.out_code, overrun0, ref_expand(b), b);
        end
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (i0.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_drained: valid=%b required 0", i0.out_valid);
        end
    endtask

    task automatic test_mid_reset;
        logic [7:0] x, y;
        int s0;
        x = 8'($urandom);
        y = 8'($urandom);
        rdy = 1'b0;
        send_code(x, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (i0.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_pre: valid=%b required 1", i0.out_valid);
        end
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        n_tests++;
        if (i0.out_valid !== 1'b0 || i0.dec !== 13'h0 || i0.out_code !== 8'h0 || overrun0 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b dec=%h code=%h ovr=%b required all 0",
                     i0.out_valid, i0.dec, i0.out_code, overrun0);
        end
        rdy = 1'b1;
        s0 = sync_seen;
        send_code(y, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (i0.out_valid !== 1'b1 || i0.dec !== ref_expand(y) || sync_seen - s0 !== 0) begin
            n_fail++;
            $display("FAIL post_reset_decode: valid=%b dec=%h serr=%0d required valid=1 dec=%h serr=0",
                     i0.out_valid, i0.dec, sync_seen - s0, ref_expand(y));
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_q [$];
        logic [7:0] c;
        logic [7:0] front;
        int x0;
        bit bad;
        x0 = xfer_seen;
        for (int k = 0; k < 60; k++) begin
            c = 8'($urandom);
            for (int i = 7; i >= 0; i--) begin
                rdy = ($urandom_range(0, 3) != 0) || (k % 16 >= 12 && $urandom_range(0, 7) == 0);
                if (k % 16 >= 12) rdy = ($urandom_range(0, 7) == 0);
                step(1'b1, i == 7, c[i]);
                if (i == 0) exp_q.push_back(c);
                if (i0.out_valid && i0.out_ready) begin
                    bad = 1'b0;
                    while (exp_q.size() > 0 && overrun0 && exp_q[0] !== i0.out_code)
                        void'(exp_q.pop_front());
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        bad = 1'b1;
                        front = 8'h0;
                    end else begin
                        front = exp_q.pop_front();
                        bad = (i0.out_code !== front) || (i0.dec !== ref_expand(front));
                    end
                    if (bad) begin
                        n_fail++;
                        $display("FAIL stream_sample: code=%h dec=%h required code=%h dec=%h",
                                 i0.out_code, i0.dec, front, ref_expand(front));
                    end
                end
            end
        end
        rdy = 1'b1;
        for (int t = 0; t < 6; t++) begin
            step(1'b0, 1'b0, 1'b0);
            if (i0.out_valid && i0.out_ready) begin
                while (exp_q.size() > 0 && overrun0 && exp_q[0] !== i0.out_code)
                    void'(exp_q.pop_front());
                n_tests++;
                front = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h0;
                if (i0.out_code !== front || i0.dec !== ref_expand(front)) begin
                    n_fail++;
                    $display("FAIL stream_drain: code=%h dec=%h required code=%h dec=%h",
                             i0.out_code, i0.dec, front, ref_expand(front));
                end
            end
        end
        n_tests++;
        if (!overrun0 && exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_loss: %0d samples missing without overrun, required 0", exp_q.size());
        end
        n_tests++;
        if (xfer_seen - x0 < 1) begin
            n_fail++;
            $display("FAIL stream_count: got %0d samples required at least 1", xfer_seen - x0);
        end
    endtask

    initial begin
        i0.out_ready = 1'b1;
        i1.out_ready = 1'b1;
        test_reset;
        test_decode;
        test_xor_mask;
        test_sync_err;
        test_overrun;
        test_mid_reset;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/g711alaw_rx_expander.md
Name: g711alaw_rx_expander

Overview:
- Receive end of the G.711 A-law link; the transmit end is the existing 13-bit sign-magnitude A-law compander.
- Deserialises an MSB-first 8-bit PCM code stream that arrives on a frame-sync/bit-enable interface.
- Expands each code to a 13-bit sign-magnitude linear sample.
- Presents each sample on a valid/ready output toward the downstream DSP filter chain.

Parameters:
- XOR_MASK, 8'h00, applied to each received code before expansion; set to 8'h55 for line-standard even-bit inversion.
- WIDTH, 13, linear output width (sign bit plus 12-bit magnitude); fixed at 13, other values unsupported.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- bit_en  in  1  one-cycle strobe; sdin and fs are sampled only when high.
- fs  in  1  frame sync, qualified by bit_en; marks the MSB (sign) bit of a code.
- sdin  in  1  serial code bit, MSB first.
- out_ready  in  1  downstream accept.
- out_valid  out  1  sample available.
- out_code  out  8  code after XOR_MASK.
- dec  out  13  linear sample, sign-magnitude: bit12 = sign, bits 11:0 = magnitude.
- overrun  out  1  sticky; a completed code was dropped.
- sync_err  out  1  one-cycle pulse; fs arrived mid-code.

Behaviour:
- Reset (reset==0 at a clock edge):
  - out_valid=0, out_code=0, dec=0, overrun=0, sync_err=0.
  - Bit counter=0, state=HUNT, stage-1 empty.
  - Applies mid-operation: any partial code and any held sample are discarded.
- Framer FSM:
  - HUNT: ignore sdin until bit_en&fs; then take that bit as bit7, cnt=1, go to SHIFT.
  - SHIFT: each bit_en shifts sdin in, cnt++.
    - On the 8th bit (cnt==7 at the strobe), the complete code is handed to stage 1.
    - Then go to HUNT if NEXT_FS_REQ... no such parameter: go to WAIT_FS.
  - WAIT_FS: behaves exactly like HUNT, but bit_en&fs in this state is a normal frame start, not an error.
  - bit_en&fs while in SHIFT with cnt!=0: drop the partial code, pulse sync_err for one cycle, restart with this bit as bit7 (cnt=1).
  - fs without bit_en is ignored.
- Stage 1 (code register):
  - Loads code^XOR_MASK on the cycle after the 8th-bit strobe and sets code_vld.
  - Advances into stage 2 whenever stage 2 loads.
- Stage 2 (output register): loads when code_vld && (!out_valid || out_ready).
  - Loaded from stage 1: out_valid=1, out_code and dec updated.
  - out_valid && out_ready with nothing to load: out_valid clears.
  - Back-to-back transfer sustains 1 sample/cycle.
- Latency: 8th-bit strobe at cycle N gives out_valid at N+2 when the output is unblocked.
- Overrun:
  - Condition: a new code completes while stage 1 is full and not advancing that cycle.
  - The new code is dropped, stage 1 keeps its old contents, overrun=1 until reset.
- Expansion (combinational, between stage 1 and stage 2). Let c = code, s = c[7], seg = c[6:4], m = c[3:0].
  - seg 000 or 001 (segment 1, 5-bit mantissa): mag = {6'b0, c[4:0], 1'b1}.
  - seg k = 2..7: mag bit (k+4) = 1, bits (k+3):k = m, bit (k-1) = 1, all lower bits 0, all higher bits 0.
  - dec = {s, mag}.
  - Maximum magnitude is 4032; no 2's-complement conversion.
- Simultaneous events:
  - Code completing while stage 2 is being drained: stage 1 loads normally.
  - fs on the 8th-bit strobe: this is cnt==7, so the strobe completes the code. fs is not treated as a new start.

Decomposition:
- Package g711_pkg:
  - Constants SEG1_CODE_MSBS=2'b00 and ALAW_MAX_MAG=12'd4032.
  - Function alaw_expand(code) returning 13-bit {s, mag}.
  - Framer state enum {HUNT, SHIFT, WAIT_FS}.
- One sub-module is natural: g711_alaw_deframer (FSM, counter, shift register, sync_err). The expansion and the two stage registers stay in the top.

Test Plan:
1. Mask 0; codes 0x00, 0x15, 0x25, 0x85, 0x7F sent with one fs each, out_ready=1 -> dec = 0x0001, 0x002B, 0x0056, 0x100B, 0x0FC0; each out_valid exactly 2 cycles after its 8th strobe.
2. XOR_MASK=8'h55; line code 0xD5 -> out_code 0x80, dec 0x1001.
3. fs issued after 4 bits of a code, then a full 0x7F -> single sync_err pulse, no output for the partial code, then dec 0x0FC0.
4. out_ready=0 while three codes are sent -> first held in stage 2, second in stage 1, third dropped. Overrun rises on the third code's completion; raising out_ready delivers samples 1 and 2 in order, then out_valid=0.
5. Assert reset for one cycle mid-code, with out_valid=1 -> next cycle out_valid=0, dec=0, overrun=0. The following fs-aligned code decodes correctly.
6. Random codes at back-to-back 8-strobe spacing with random out_ready -> scoreboard matches alaw_expand, no loss unless overrun is flagged.
